// File: rtl/digit_serial_adder_pkg.sv
// Shared types for the digit-serial adder.
//   state_t   : control FSM encoding (IDLE, RUN, DONE)
//   cnt_width : digit-counter width for a given digit count (min 1 bit)
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational W-bit ripple-carry adder built from full_Adder cells.
// Ports: a, b [W-1:0], cin (inputs); sum [W-1:0], cout (outputs).
module digit_adder #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] carry;

    assign carry[0] = cin;

    // Ripple chain, LSB first
    for (genvar i = 0; i < W; i++) begin : g_bit
        full_Adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .sum (sum[i]),
            .cout(carry[i+1])
        );
    end

    assign cout = carry[W];

endmodule

// File: rtl/full_Adder.sv
// Single-bit full adder cell.
// Ports: a, b, cin (inputs); sum, cout (outputs).
module full_Adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per cycle.
// Accepts operands in IDLE (in_valid/in_ready), spends N = WIDTH/DIGIT
// cycles in RUN, then presents sum/cout in DONE (out_valid/out_ready).
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid, in_ready   : operand handshake
//   a, b, cin            : operands and carry-in
//   sub                  : subtract select (only with DIGIT_SERIAL_ADDER_ADD_SUB_EN)
//   out_valid, out_ready : result handshake
//   sum, cout            : registered result and carry-out of the MSB digit
// Optional feature macro: DIGIT_SERIAL_ADDER_ADD_SUB_EN (A-B via ~B and carry seed 1).
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef DIGIT_SERIAL_ADDER_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = cnt_width(N);

    state_t             state_q, state_n;
    logic               accept_c, step_c, last_c;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DIGIT-1:0]   dsum_c;
    logic               dcout_c;
    logic               sub_c;
    logic [WIDTH-1:0]   b_in_c;
    logic               seed_c;

`ifdef DIGIT_SERIAL_ADDER_ADD_SUB_EN
    assign sub_c = sub;
`else
    assign sub_c = 1'b0;
`endif

    // Subtraction is A + ~B + 1; cin is ignored in that mode
    assign b_in_c = sub_c ? ~b : b;
    assign seed_c = sub_c ? 1'b1 : cin;

    // Next-state and per-cycle control
    always_comb begin
        state_n  = state_q;
        accept_c = 1'b0;
        step_c   = 1'b0;
        last_c   = (cnt_q == CNT_W'(N - 1));
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_n  = RUN;
                end
            end
            RUN: begin
                step_c = 1'b1;
                if (last_c) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_n;
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == DONE);
        end
    end

    // Adds the current low digit of the shifted operands
    digit_adder #(.W(DIGIT)) u_digit (
        .a   (a_q[DIGIT-1:0]),
        .b   (b_q[DIGIT-1:0]),
        .cin (carry_q),
        .sum (dsum_c),
        .cout(dcout_c)
    );

    // Operand shift registers, carry, digit counter and result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (accept_c) begin
            a_q     <= a;
            b_q     <= b_in_c;
            carry_q <= seed_c;
            cnt_q   <= '0;
        end else if (step_c) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            carry_q <= dcout_c;
            cnt_q   <= cnt_q + CNT_W'(1);
            // Only digit k of the result changes in step k
            for (int k = 0; k < int'(N); k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    sum[k*DIGIT +: DIGIT] <= dsum_c;
                end
            end
            if (last_c) begin
                cout <= dcout_c;
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: a 16/4 instance and an 8/8 instance.
module tb_digit_serial_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 16-bit / 4-bit-digit instance
    logic        iv16 = 1'b0, rdy16, ov16, or16 = 1'b1, co16, cin16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, s16;
    // 8-bit / 8-bit-digit instance
    logic        iv8 = 1'b0, rdy8, ov8, or8 = 1'b1, co8, cin8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, s8;

    exp_t q16[$];
    exp_t q8[$];

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16),
        .a(a16), .b(b16), .cin(cin16),
`ifdef DIGIT_SERIAL_ADDER_ADD_SUB_EN
        .sub(sub16),
`endif
        .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8),
        .a(a8), .b(b8), .cin(cin8),
`ifdef DIGIT_SERIAL_ADDER_ADD_SUB_EN
        .sub(sub8),
`endif
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: latency on rising out_valid, result compare on every DONE cycle
    int   acc16 = 0, acc8 = 0;
    logic ovp16 = 1'b0, ovp8 = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (iv16 && rdy16) acc16 = cyc;
            if (iv8 && rdy8) acc8 = cyc;
            if (ov16) begin
                if (!ovp16) chk("lat16", 32'(cyc - acc16), 32'd5);
                if (q16.size() == 0) chk("unexpected16", 32'd1, 32'd0);
                else begin
                    chk("sum16", 32'(s16), 32'(q16[0].sum));
                    chk("cout16", 32'(co16), 32'(q16[0].cout));
                    if (or16) void'(q16.pop_front());
                end
            end
            if (ov8) begin
                if (!ovp8) chk("lat8", 32'(cyc - acc8), 32'd2);
                if (q8.size() == 0) chk("unexpected8", 32'd1, 32'd0);
                else begin
                    chk("sum8", 32'(s8), 32'(q8[0].sum));
                    chk("cout8", 32'(co8), 32'(q8[0].cout));
                    if (or8) void'(q8.pop_front());
                end
            end
            ovp16 = ov16;
            ovp8  = ov8;
        end else begin
            ovp16 = 1'b0;
            ovp8  = 1'b0;
        end
    end

    task automatic wait_accept16();
        logic hs = 1'b0;
        int   budget = 0;
        while (!hs && budget < 40) begin
            hs = rdy16;
            step();
            budget++;
        end
        if (!hs) chk("accept16_timeout", 32'd1, 32'd0);
        iv16 = 1'b0;
    endtask

    task automatic send16(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                          input logic ts, input logic push, input logic [15:0] es, input logic ec);
        exp_t e;
        a16 = ta; b16 = tb; cin16 = tc; sub16 = ts; iv16 = 1'b1;
        e.sum = es; e.cout = ec;
        if (push) q16.push_back(e);
        wait_accept16();
    endtask

    task automatic send8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                         input logic [7:0] es, input logic ec);
        exp_t e;
        logic hs = 1'b0;
        int   budget = 0;
        a8 = ta; b8 = tb; cin8 = tc; iv8 = 1'b1;
        e.sum = 16'(es); e.cout = ec;
        q8.push_back(e);
        while (!hs && budget < 40) begin
            hs = rdy8;
            step();
            budget++;
        end
        if (!hs) chk("accept8_timeout", 32'd1, 32'd0);
        iv8 = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while ((q16.size() != 0 || q8.size() != 0) && budget < 60) begin
            step();
            budget++;
        end
        if (q16.size() != 0 || q8.size() != 0) chk("drain_timeout", 32'd1, 32'd0);
        step();
    endtask

    initial begin
        int budget;
        #23;
        chk("rst_in_ready", 32'(rdy16), 32'd1);
        chk("rst_out_valid", 32'(ov16), 32'd0);
        chk("rst_sum", 32'(s16), 32'd0);
        chk("rst_cout", 32'(co16), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Plain addition and full carry ripple
        send16(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0);
        drain();
        send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
        drain();

        // Result held while idle
        repeat (3) step();
        chk("idle_sum", 32'(s16), 32'h0000);
        chk("idle_cout", 32'(co16), 32'd1);
        chk("idle_out_valid", 32'(ov16), 32'd0);

        // Back-pressure in DONE with new operands offered
        or16 = 1'b0;
        send16(16'h00FF, 16'h0F01, 1'b1, 1'b0, 1'b1, 16'h1001, 1'b0);
        budget = 0;
        while (!ov16 && budget < 20) begin
            step();
            budget++;
        end
        chk("stall_reached_done", 32'(ov16), 32'd1);
        a16 = 16'h8000; b16 = 16'h8000; cin16 = 1'b0; iv16 = 1'b1;
        begin
            exp_t e;
            e.sum = 16'h0000; e.cout = 1'b1;
            q16.push_back(e);
        end
        repeat (3) begin
            step();
            chk("stall_in_ready", 32'(rdy16), 32'd0);
            chk("stall_out_valid", 32'(ov16), 32'd1);
        end
        or16 = 1'b1;
        wait_accept16();
        drain();

        send16(16'h0F0F, 16'h1010, 1'b0, 1'b0, 1'b1, 16'h1F1F, 1'b0);
        drain();

        // Reset in RUN cycle 2 aborts the operation
        send16(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step();
        step();
        rst = 1'b1;
        #2;
        chk("abort_out_valid", 32'(ov16), 32'd0);
        chk("abort_sum", 32'(s16), 32'd0);
        chk("abort_cout", 32'(co16), 32'd0);
        step();
        rst = 1'b0;
        chk("abort_in_ready", 32'(rdy16), 32'd1);
        step();
        send16(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0);
        drain();

`ifdef DIGIT_SERIAL_ADDER_ADD_SUB_EN
        send16(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        drain();
        send16(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b1);
        drain();
        sub16 = 1'b0;
`endif

        // Single-digit instance
        send8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        drain();
        send8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of DIGIT, and N = WIDTH/DIGIT.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: operands offered.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have port a, input, WIDTH: operand A.
REQ-008 SHALL have port b, input, WIDTH: operand B.
REQ-009 SHALL have port cin, input, 1: carry-in.
REQ-010 SHALL have port sub, input, 1: subtract select (present only with ADD_SUB_EN).
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-013 SHALL have port sum, output, WIDTH: registered result.
REQ-014 SHALL have port cout, output, 1: registered carry-out of the MSB digit.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-016 SHALL, in IDLE with in_valid=1, latch a, b, cin (and sub), clear the digit counter, and enter RUN next cycle; in_valid in RUN/DONE SHALL be ignored.
REQ-017 SHALL, in each RUN cycle k (0..N-1), add digit k of A, digit k of B and the carry register, write the DIGIT-bit result into sum[k*DIGIT +: DIGIT], and update the carry register (cin seeds k=0).
REQ-018 SHALL enter DONE after the cycle with k=N-1, with cout equal to the final carry; latency from accept to out_valid=1 is exactly N+1 cycles.
REQ-019 SHALL hold sum, cout, out_valid stable in DONE until out_ready=1; DONE with out_ready=1 SHALL return to IDLE next cycle.
REQ-020 SHALL leave sum/cout unchanged from the previous result while in IDLE and only overwrite them digit by digit in RUN.
REQ-021 SHALL compute results modulo 2^WIDTH; N=1 (WIDTH=DIGIT) SHALL work with a single RUN cycle.

Reset
REQ-022 SHALL, on rst=1, immediately force state IDLE, in_ready=1 after release, out_valid=0, sum=0, cout=0, carry register=0, digit counter=0.
REQ-023 SHALL abort any operation in RUN or DONE on reset with no result delivered.

Configuration
REQ-024 SHALL support macro DIGIT_SERIAL_ADDER_ADD_SUB_EN: when defined, port sub exists and sub=1 computes A-B by inverting B digits and seeding carry with 1 (cin ignored), cout=1 meaning no borrow.
REQ-025 SHALL, without DIGIT_SERIAL_ADDER_ADD_SUB_EN, omit port sub and perform addition only.

Structure
REQ-026 SHALL place the FSM state typedef (IDLE, RUN, DONE) and its encoding in package digit_serial_adder_pkg.
REQ-027 SHALL use one sub-module, digit_adder: combinational DIGIT-bit ripple-carry adder built from the existing full_Adder cell, ports a, b, cin, sum, cout.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-028 SHALL test 0x1234+0x4321, cin=0 -> sum=0x5555, cout=0, out_valid exactly 5 cycles after accept.
REQ-029 SHALL test 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1 (carry through all 4 digits).
REQ-030 SHALL test out_ready held 0 for 3 cycles in DONE with in_valid=1 and new operands -> sum/cout stable, in_ready=0, new operands not taken until after return to IDLE.
REQ-031 SHALL test rst pulsed during RUN cycle 2 -> out_valid=0, sum=0, state IDLE; next 0x0001+0x0001 -> 0x0002.
REQ-032 SHALL test, with DIGIT_SERIAL_ADDER_ADD_SUB_EN, sub=1 on 0x0005-0x0007 -> sum=0xFFFE, cout=0; and on 0x0007-0x0005 -> 0x0002, cout=1.
REQ-033 SHALL test WIDTH=8, DIGIT=8: 0x80+0x80 -> sum=0x00, cout=1, out_valid 2 cycles after accept.
